dmem_arbiter: RTL and testbench

- Shares the single data-memory port (dmem) between two requesters: the CPU datapath data port and a debug/loader port that preloads or inspects dmem.
- Owns the memory-mapped I/O decode: the LED output register at 0x8000 and the switch input at 0x8008.
- Sits between the datapath/debug logic and dmem, inside the processor top level.
- Round-robin arbitration, one transaction per grant, with a req/ack handshake.

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/sync2.sv | 23 ++
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, RESP} arb_state_t;
    typedef enum logic {REQ_CPU, REQ_DBG} req_id_t;

    localparam logic [63:0] LED_ADDR_DEF = 64'h8000;
    localparam logic [63:0] SW_ADDR_DEF  = 64'h8008;

    localparam int unsigned MEM_IDX_HI = 8;
    localparam int unsigned MEM_IDX_LO = 3;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for slow asynchronous level inputs.
module sync2 #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            q_o    <= '0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing dmem between CPU and debug ports, with LED/switch MMIO decode.
// Optional grant counters are enabled with `define DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned   N        = 64,
    parameter logic [N-1:0]  LED_ADDR = N'(LED_ADDR_DEF),
    parameter logic [N-1:0]  SW_ADDR  = N'(SW_ADDR_DEF)
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [N-1:0] cpu_addr,
    input  logic [N-1:0] cpu_wdata,
    output logic [N-1:0] cpu_rdata,
    output logic         cpu_ack,

    input  logic         dbg_req,
    input  logic         dbg_we,
    input  logic [N-1:0] dbg_addr,
    input  logic [N-1:0] dbg_wdata,
    output logic [N-1:0] dbg_rdata,
    output logic         dbg_ack,

    output logic [5:0]   mem_addr,
    output logic         mem_we,
    output logic         mem_re,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,

    input  logic [15:0]  sw_in,
    output logic [15:0]  led_out
`ifdef DMEM_ARB_PERF_EN
    ,
    input  logic         perf_clr,
    output logic [31:0]  cpu_grant_cnt,
    output logic [31:0]  dbg_grant_cnt
`endif
);

    arb_state_t   state_q;
    req_id_t      sel_q;
    req_id_t      last_grant_q;
    req_id_t      next_sel;
    logic         grant_entry;

    logic         g_we;
    logic [N-1:0] g_addr;
    logic [N-1:0] g_wdata;
    logic         is_led;
    logic         is_sw;
    logic         is_mmio;
    logic [N-1:0] rd_val;
    logic [15:0]  sw_sync;

    sync2 #(
        .W (16)
    ) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (sw_in),
        .q_o   (sw_sync)
    );

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant_entry = (state_q == IDLE) && (cpu_req || dbg_req);
        if (cpu_req && dbg_req) begin
            next_sel = (last_grant_q == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (cpu_req) begin
            next_sel = REQ_CPU;
        end else begin
            next_sel = REQ_DBG;
        end
    end

    always_comb begin
        g_we    = (sel_q == REQ_CPU) ? cpu_we    : dbg_we;
        g_addr  = (sel_q == REQ_CPU) ? cpu_addr  : dbg_addr;
        g_wdata = (sel_q == REQ_CPU) ? cpu_wdata : dbg_wdata;
        is_led  = (g_addr == LED_ADDR);
        is_sw   = (g_addr == SW_ADDR);
        is_mmio = is_led || is_sw;
        if (is_led) begin
            rd_val = {{(N-16){1'b0}}, led_out};
        end else if (is_sw) begin
            rd_val = {{(N-16){1'b0}}, sw_sync};
        end else begin
            rd_val = mem_rdata;
        end
    end

    // Decoded from the state so an asynchronous reset kills mem_we at once.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = '0;
        if (state_q == GRANT && !is_mmio) begin
            mem_addr  = g_addr[MEM_IDX_HI:MEM_IDX_LO];
            mem_we    = g_we;
            mem_re    = !g_we;
            mem_wdata = g_wdata;
        end
    end

    assign cpu_ack = (state_q == RESP) && (sel_q == REQ_CPU);
    assign dbg_ack = (state_q == RESP) && (sel_q == REQ_DBG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= REQ_CPU;
            last_grant_q <= REQ_DBG;
            cpu_rdata    <= '0;
            dbg_rdata    <= '0;
            led_out      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_entry) begin
                        sel_q        <= next_sel;
                        last_grant_q <= next_sel;
                        state_q      <= GRANT;
                    end
                end
                GRANT: begin
                    if (!g_we) begin
                        if (sel_q == REQ_CPU) begin
                            cpu_rdata <= rd_val;
                        end else begin
                            dbg_rdata <= rd_val;
                        end
                    end else if (is_led) begin
                        led_out <= g_wdata[15:0];
                    end
                    state_q <= RESP;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_grant_cnt <= '0;
            dbg_grant_cnt <= '0;
        end else if (perf_clr) begin
            cpu_grant_cnt <= '0;
            dbg_grant_cnt <= '0;
        end else if (grant_entry) begin
            if (next_sel == REQ_CPU && cpu_grant_cnt != 32'hFFFF_FFFF) begin
                cpu_grant_cnt <= cpu_grant_cnt + 32'd1;
            end
            if (next_sel == REQ_DBG && dbg_grant_cnt != 32'hFFFF_FFFF) begin
                dbg_grant_cnt <= dbg_grant_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [63:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [5:0]  mem_addr;
    logic        mem_we, mem_re;
    logic [63:0] mem_wdata, mem_rdata;
    logic [15:0] sw_in, led_out;
`ifdef DMEM_ARB_PERF_EN
    logic        perf_clr;
    logic [31:0] cpu_grant_cnt, dbg_grant_cnt;
`endif

    int checks;
    int failures;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .dbg_ack   (dbg_ack),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .sw_in     (sw_in),
        .led_out   (led_out)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_clr      (perf_clr),
        .cpu_grant_cnt (cpu_grant_cnt),
        .dbg_grant_cnt (dbg_grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction: drive, check the GRANT cycle, check the ack cycle, release.
    task automatic txn(input string tag, input bit dbg, input bit we,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] mrd, input bit ewe, input bit ere,
                       input logic [63:0] eaddr, input logic [63:0] erd);
        @(negedge clk);
        mem_rdata = mrd;
        if (dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        @(negedge clk);
        chk({tag, ".mem_we"}, mem_we, ewe);
        chk({tag, ".mem_re"}, mem_re, ere);
        if (ewe || ere) chk({tag, ".mem_addr"}, mem_addr, eaddr);
        if (ewe) chk({tag, ".mem_wdata"}, mem_wdata, wdata);
        chk({tag, ".early_ack"}, cpu_ack | dbg_ack, 0);
        @(negedge clk);
        chk({tag, ".cpu_ack"}, cpu_ack, !dbg);
        chk({tag, ".dbg_ack"}, dbg_ack, dbg);
        chk({tag, ".rdata"}, dbg ? dbg_rdata : cpu_rdata, erd);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        mem_rdata = 0; sw_in = 0;
`ifdef DMEM_ARB_PERF_EN
        perf_clr = 0;
`endif
        repeat (2) @(negedge clk);
        chk("rst.cpu_ack", cpu_ack, 0);
        chk("rst.dbg_ack", dbg_ack, 0);
        chk("rst.mem_we", mem_we, 0);
        chk("rst.mem_re", mem_re, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.led", led_out, 0);
        chk("rst.cpu_rdata", cpu_rdata, 0);
        reset = 1'b0;

        // dmem write then read back through the CPU port
        txn("wr10", 0, 1, 64'h10, 64'hABCD, 64'h0, 1, 0, 2, 64'h0);
        txn("rd10", 0, 0, 64'h10, 64'h0, 64'hABCD, 0, 1, 2, 64'hABCD);

        // LED register
        txn("ledwr", 0, 1, 64'h8000, 64'h5A5A, 64'h0, 0, 0, 0, 64'hABCD);
        chk("ledwr.led", led_out, 64'h5A5A);
        txn("ledrd", 0, 0, 64'h8000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 64'h5A5A);

        // Switch input via the debug port
        sw_in = 16'h1234;
        repeat (3) @(negedge clk);
        txn("swrd", 1, 0, 64'h8008, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 64'h1234);
        txn("swwr", 1, 1, 64'h8008, 64'hFFFF, 64'h0, 0, 0, 0, 64'h1234);
        chk("swwr.led", led_out, 64'h5A5A);

        // High address bits and addr[2:0] ignored: 0x1_0000_004D -> word 9
        txn("alias", 1, 1, 64'h1_0000_004D, 64'h5555, 64'h0, 1, 0, 9, 64'h1234);

        // Both requesting continuously: strict alternation starting with CPU
        @(negedge clk);
        mem_rdata = 64'h77;
        cpu_req = 1; cpu_we = 0; cpu_addr = 64'h18;
        dbg_req = 1; dbg_we = 0; dbg_addr = 64'h20;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr.mem_addr", mem_addr, (i % 2 == 1) ? 64'd4 : 64'd3);
            chk("rr.mem_re", mem_re, 1);
            @(negedge clk);
            chk("rr.cpu_ack", cpu_ack, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr.dbg_ack", dbg_ack, (i % 2 == 1) ? 64'd1 : 64'd0);
            @(negedge clk);
            chk("rr.idle_ack", cpu_ack | dbg_ack, 0);
        end
        cpu_req = 0; dbg_req = 0;
        chk("rr.cpu_rdata", cpu_rdata, 64'h77);
        chk("rr.dbg_rdata", dbg_rdata, 64'h77);

        // Reset during the GRANT cycle of a CPU write
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 64'h28; cpu_wdata = 64'h1111;
        @(negedge clk);
        chk("rstg.mem_we_before", mem_we, 1);
        #1 reset = 1'b1;
        #1 chk("rstg.mem_we_drop", mem_we, 0);
        cpu_req = 0;
        @(negedge clk);
        chk("rstg.no_ack", cpu_ack, 0);
        chk("rstg.led", led_out, 0);
        reset = 1'b0;

        // After reset the CPU wins the first tie
        mem_rdata = 64'h0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 64'h18;
        dbg_req = 1; dbg_we = 0; dbg_addr = 64'h20;
        @(negedge clk);
        chk("tie.mem_addr", mem_addr, 3);
        @(negedge clk);
        chk("tie.cpu_ack", cpu_ack, 1);
        chk("tie.dbg_ack", dbg_ack, 0);
        @(posedge clk);
        #1;
        cpu_req = 0; dbg_req = 0;

`ifdef DMEM_ARB_PERF_EN
        // Clear coinciding with a grant entry wins over the increment
        @(negedge clk);
        perf_clr = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 64'h30;
        @(negedge clk);
        perf_clr = 0;
        chk("perf.clr_cpu", cpu_grant_cnt, 0);
        chk("perf.clr_dbg", dbg_grant_cnt, 0);
        @(negedge clk);
        @(posedge clk);
        #1 cpu_req = 0;
        for (int i = 0; i < 5; i++) txn("perf.cpu", 0, 0, 64'h30, 64'h0, 64'h0, 0, 1, 6, 64'h0);
        for (int i = 0; i < 3; i++) txn("perf.dbg", 1, 0, 64'h30, 64'h0, 64'h0, 0, 1, 6, 64'h0);
        chk("perf.cpu_cnt", cpu_grant_cnt, 5);
        chk("perf.dbg_cnt", dbg_grant_cnt, 3);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
